// File: rtl/div_seq_signed.sv
// div_seq_signed: sequential signed divider, one restoring quotient bit per clock.
// A start pulse captures the operands. WIDTH CALC steps produce the magnitude results.
// One FIX cycle applies the signs, registers the results and pulses done.
// Truncates toward zero, so the remainder takes the sign of the dividend.
// Optional macro DIVSEQ_ZERO_FAST_EN: a zero divisor skips CALC and finishes
// one edge after the accepted start.
module div_seq_signed #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quot,
  output logic [WIDTH-1:0] rem,
  output logic             div_zero,
  output logic             ovf
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;

  state_t         state, state_next;
  logic [CW-1:0]  count;
  // Holds |a| at the start. Quotient bits shift in from the LSB as dividend bits shift out.
  logic [WIDTH-1:0] dq;
  // The partial remainder is always below |b| <= 2^(WIDTH-1), so WIDTH bits suffice.
  logic [WIDTH-1:0] prem;
  logic [WIDTH:0]   bmag;
  logic [WIDTH-1:0] a_hold;
  logic             a_neg, q_neg, zero_flag, ovf_flag;

  // Operand conditioning for the capture edge.
  logic [WIDTH-1:0] a_mag;
  logic [WIDTH:0]   b_ext, b_mag;
  logic             b_is_zero, a_is_min, b_is_m1;
  // Single shared subtractor for the restoring step.
  logic [WIDTH:0]   shifted, trial;
  logic             last_step;

  assign a_mag     = a[WIDTH-1] ? -a : a;
  assign b_ext     = {b[WIDTH-1], b};
  assign b_mag     = b[WIDTH-1] ? -b_ext : b_ext;
  assign b_is_zero = (b == '0);
  assign a_is_min  = (a == {1'b1, {(WIDTH-1){1'b0}}});
  assign b_is_m1   = (b == '1);
  assign shifted   = {prem, dq[WIDTH-1]};
  assign trial     = shifted - bmag;
  assign last_step = (count == CW'(WIDTH - 1));
  assign busy      = (state != IDLE);

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  // Next-state logic: start is only looked at in IDLE.
  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (start) begin
`ifdef DIVSEQ_ZERO_FAST_EN
          state_next = b_is_zero ? FIX : CALC;
`else
          state_next = CALC;
`endif
        end
      end
      CALC:    if (last_step) state_next = FIX;
      FIX:     state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Operand capture and restoring-division datapath.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count     <= '0;
      dq        <= '0;
      prem      <= '0;
      bmag      <= '0;
      a_hold    <= '0;
      a_neg     <= 1'b0;
      q_neg     <= 1'b0;
      zero_flag <= 1'b0;
      ovf_flag  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            dq        <= a_mag;
            bmag      <= b_mag;
            prem      <= '0;
            count     <= '0;
            a_hold    <= a;
            a_neg     <= a[WIDTH-1];
            q_neg     <= a[WIDTH-1] ^ b[WIDTH-1];
            zero_flag <= b_is_zero;
            ovf_flag  <= a_is_min & b_is_m1;
          end
        end
        CALC: begin
          // A negative trial means |b| did not fit, so keep the shifted value (restore).
          prem  <= trial[WIDTH] ? shifted[WIDTH-1:0] : trial[WIDTH-1:0];
          dq    <= {dq[WIDTH-2:0], ~trial[WIDTH]};
          count <= count + 1'b1;
        end
        default: ;
      endcase
    end
  end

  // Result registers: they load only in FIX and otherwise hold, even across a new start.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      done     <= 1'b0;
      quot     <= '0;
      rem      <= '0;
      div_zero <= 1'b0;
      ovf      <= 1'b0;
    end else begin
      done <= (state == FIX);
      if (state == FIX) begin
        div_zero <= zero_flag;
        ovf      <= ovf_flag;
        if (zero_flag) begin
          quot <= '1;
          rem  <= a_hold;
        end else begin
          // The most-negative / -1 case wraps naturally: |q| = 2^(WIDTH-1) reads back as most-negative.
          quot <= q_neg ? -dq : dq;
          rem  <= a_neg ? -prem : prem;
        end
      end
    end
  end

endmodule

// File: tb/tb_div_seq_signed.sv
// tb_div_seq_signed: directed vectors for div_seq_signed (WIDTH=4).
// The driver pushes the expected results and the due cycle into a scoreboard queue.
// A monitor pops and compares on each done pulse.
// Between done pulses the monitor checks that the result registers hold.
module tb_div_seq_signed;

  localparam int W = 4;
`ifdef DIVSEQ_ZERO_FAST_EN
  localparam int ZL = 1;
`else
  localparam int ZL = 5;
`endif

  logic         clk;
  logic         rst_n;
  logic         start;
  logic [W-1:0] a, b;
  logic         busy, done, div_zero, ovf;
  logic [W-1:0] quot, rem;

  div_seq_signed #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .a(a), .b(b),
    .busy(busy), .done(done), .quot(quot), .rem(rem),
    .div_zero(div_zero), .ovf(ovf)
  );

  typedef struct {
    logic [W-1:0] q;
    logic [W-1:0] r;
    logic         dz;
    logic         ov;
    int           due;
    int           lat;
  } exp_t;

  exp_t sb[$];
  int   applied = 0;
  int   miss    = 0;
  int   cyc     = 0;

  logic [W-1:0] hold_q = '0, hold_r = '0;
  logic         hold_dz = 1'b0, hold_ov = 1'b0;
  int           busy_run = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Cycle counter, used for latency checks.
  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: checks results on done, checks that results hold on every other cycle, and checks reset.
  always @(negedge clk) begin
    exp_t e;
    if (!rst_n) begin
      hold_q = '0; hold_r = '0; hold_dz = 1'b0; hold_ov = 1'b0;
      busy_run = 0;
      applied++;
      if (busy !== 1'b0 || done !== 1'b0) begin
        miss++;
        $display("FAIL reset_ctrl busy=%b done=%b expected 0 0", busy, done);
      end
    end
    if (done === 1'b1) begin
      if (sb.size() == 0) begin
        applied++; miss++;
        $display("FAIL unexpected_done at cycle %0d quot=%h rem=%h", cyc, quot, rem);
      end else begin
        e = sb.pop_front();
        applied++;
        if ({quot, rem, div_zero, ovf} !== {e.q, e.r, e.dz, e.ov}) begin
          miss++;
          $display("FAIL result got q=%h r=%h dz=%b ovf=%b expected q=%h r=%h dz=%b ovf=%b",
                   quot, rem, div_zero, ovf, e.q, e.r, e.dz, e.ov);
        end else
          $display("ok result q=%h r=%h dz=%b ovf=%b at cycle %0d", quot, rem, div_zero, ovf, cyc);
        applied++;
        if (cyc != e.due) begin
          miss++;
          $display("FAIL latency done at cycle %0d expected cycle %0d", cyc, e.due);
        end
        applied++;
        if (busy_run != e.lat) begin
          miss++;
          $display("FAIL busy_len got %0d cycles expected %0d", busy_run, e.lat);
        end
        hold_q = e.q; hold_r = e.r; hold_dz = e.dz; hold_ov = e.ov;
      end
    end else begin
      applied++;
      if ({quot, rem, div_zero, ovf} !== {hold_q, hold_r, hold_dz, hold_ov}) begin
        miss++;
        $display("FAIL hold got q=%h r=%h dz=%b ovf=%b expected q=%h r=%h dz=%b ovf=%b",
                 quot, rem, div_zero, ovf, hold_q, hold_r, hold_dz, hold_ov);
      end
    end
    if (busy === 1'b1) busy_run++;
    else               busy_run = 0;
  end

  // Drives one start pulse and records the expected outcome.
  // The caller must make sure the DUT is idle or in its done cycle.
  task automatic op(input logic [W-1:0] ai, input logic [W-1:0] bi,
                    input logic [W-1:0] qe, input logic [W-1:0] re,
                    input logic dze, input logic ove, input int lat);
    exp_t e;
    start = 1'b1; a = ai; b = bi;
    @(posedge clk); #1;
    e.q = qe; e.r = re; e.dz = dze; e.ov = ove; e.due = cyc + lat; e.lat = lat;
    sb.push_back(e);
    start = 1'b0;
    a = W'($urandom);
    b = W'($urandom);
  endtask

  // Waits until every expected result has been seen, with a bounded wait.
  task automatic drain();
    int n = 0;
    while ((sb.size() != 0 || busy === 1'b1) && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (n >= 40) begin
      applied++; miss++;
      $display("FAIL drain_timeout pending=%0d busy=%b", sb.size(), busy);
      sb.delete();
    end
    @(negedge clk);
  endtask

  initial begin
    int n;
    rst_n = 1'b0; start = 1'b0; a = '0; b = '0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);

    // Basic signed cases.
    op(4'b0111, 4'b0010, 4'b0011, 4'b0001, 1'b0, 1'b0, 5); drain();
    op(4'b1001, 4'b0010, 4'b1101, 4'b1111, 1'b0, 1'b0, 5); drain();
    op(4'b0111, 4'b1110, 4'b1101, 4'b0001, 1'b0, 1'b0, 5); drain();
    op(4'b1001, 4'b1110, 4'b0011, 4'b1111, 1'b0, 1'b0, 5); drain();
    // Overflow, then most-negative divided by 1.
    op(4'b1000, 4'b1111, 4'b1000, 4'b0000, 1'b0, 1'b1, 5); drain();
    op(4'b1000, 4'b0001, 4'b1000, 4'b0000, 1'b0, 1'b0, 5); drain();
    op(4'b1000, 4'b0011, 4'b1110, 4'b1110, 1'b0, 1'b0, 5); drain();
    op(4'b1111, 4'b0100, 4'b0000, 4'b1111, 1'b0, 1'b0, 5); drain();
    op(4'b1000, 4'b1000, 4'b0001, 4'b0000, 1'b0, 1'b0, 5); drain();
    // Divide by zero.
    op(4'b0101, 4'b0000, 4'b1111, 4'b0101, 1'b1, 1'b0, ZL); drain();
    op(4'b1000, 4'b0000, 4'b1111, 4'b1000, 1'b1, 1'b0, ZL); drain();

    // A start while busy is ignored. The next start is issued in the done cycle.
    op(4'b0110, 4'b0011, 4'b0010, 4'b0000, 1'b0, 1'b0, 5);
    @(posedge clk); #1;
    start = 1'b1; a = 4'b0001; b = 4'b0001;
    @(posedge clk); #1;
    start = 1'b0;
    n = 0;
    @(negedge clk);
    while (done !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (n >= 20) begin
      applied++; miss++;
      $display("FAIL done_wait timeout done=%b", done);
    end
    op(4'b0111, 4'b0011, 4'b0010, 4'b0001, 1'b0, 1'b0, 5); drain();

    // Reset in mid-operation: no result is expected and the outputs clear.
    start = 1'b1; a = 4'b0111; b = 4'b0001;
    @(posedge clk); #1 start = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    @(posedge clk); #1 rst_n = 1'b1;
    repeat (8) @(negedge clk);
    op(4'b0100, 4'b0010, 4'b0010, 4'b0000, 1'b0, 1'b0, 5); drain();
    repeat (3) @(negedge clk);

    applied++;
    if (sb.size() != 0) begin
      miss++;
      $display("FAIL leftover_expected pending=%0d expected 0", sb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", applied, miss);
    $finish;
  end

endmodule
